// File: rtl/signal_sequencer.sv
// signal_sequencer
//   Drives four approach lights (N, E, S, W) through a fixed round-robin of
//   GREEN -> YELLOW -> ALL_RED phases. Phase durations are counted in whole
//   seconds, derived from clk by an internal prescaler.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset (0 = reset)
//   en           1 = run, 0 = freeze prescaler, timer, state and outputs
//   TGn..TGw     adapted green time per road, seconds (0 is floored)
//   next_road    road to be served next (0=N 1=E 2=S 3=W)
//   cur_road     road currently or last served
//   light_n..w   00 red, 01 yellow, 10 green
//   sec_left     seconds remaining in the current phase, N..1
//   phase_done   one-cycle pulse on the GREEN -> YELLOW transition
module signal_sequencer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int YELLOW_S      = 3,
  parameter int ALL_RED_S     = 2,
  parameter int MIN_GREEN     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
  output logic [1:0] next_road,
  output logic [1:0] cur_road,
  output logic [1:0] light_n,
  output logic [1:0] light_e,
  output logic [1:0] light_s,
  output logic [1:0] light_w,
  output logic [7:0] sec_left,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  localparam int              PS_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      YEL_S  = 8'(YELLOW_S);
  localparam logic [7:0]      RED_S  = 8'(ALL_RED_S);
  localparam logic [7:0]      MIN_G  = 8'(MIN_GREEN);

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  // Green length floor; also catches TG=0.
  function automatic logic [7:0] floor_green(input logic [7:0] tg);
    return (tg < MIN_G) ? MIN_G : tg;
  endfunction

  // Light colour for one road given the next state and served road.
  function automatic logic [1:0] road_light(input state_t st, input logic [1:0] cur,
                                            input logic [1:0] road);
    if (cur != road)       return L_RED;
    if (st == ST_GREEN)    return L_GREEN;
    if (st == ST_YELLOW)   return L_YELLOW;
    return L_RED;
  endfunction

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [7:0]      sec_q, sec_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      next_q, next_d;
  logic            pd_q, pd_d;
  logic [1:0]      ln_q, le_q, ls_q, lw_q;
  logic [1:0]      ln_d, le_d, ls_d, lw_d;
  logic [7:0]      tg_sel;
  logic            tick;

  assign tick = (ps_q == PS_MAX) && en;

  always_comb begin
    case (next_q)
      2'd0:    tg_sel = TGn;
      2'd1:    tg_sel = TGe;
      2'd2:    tg_sel = TGs;
      default: tg_sel = TGw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    sec_d   = sec_q;
    cur_d   = cur_q;
    next_d  = next_q;
    pd_d    = 1'b0;
    if (en) begin
      // Wrap on tick; every phase entry happens on a tick, so this also
      // restarts the prescaler at each new phase.
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        if (sec_q > 8'd1) begin
          sec_d = sec_q - 8'd1;
        end else begin
          case (state_q)
            ST_ALL_RED: begin
              state_d = ST_GREEN;
              cur_d   = next_q;
              next_d  = next_q + 2'd1;
              sec_d   = floor_green(tg_sel);
            end
            ST_GREEN: begin
              state_d = ST_YELLOW;
              sec_d   = YEL_S;
              pd_d    = 1'b1;
            end
            default: begin
              state_d = ST_ALL_RED;
              sec_d   = RED_S;
            end
          endcase
        end
      end
    end
    ln_d = road_light(state_d, cur_d, 2'd0);
    le_d = road_light(state_d, cur_d, 2'd1);
    ls_d = road_light(state_d, cur_d, 2'd2);
    lw_d = road_light(state_d, cur_d, 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ALL_RED;
      ps_q    <= '0;
      sec_q   <= RED_S;
      cur_q   <= 2'd3;
      next_q  <= 2'd0;
      pd_q    <= 1'b0;
      ln_q    <= L_RED;
      le_q    <= L_RED;
      ls_q    <= L_RED;
      lw_q    <= L_RED;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      sec_q   <= sec_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      pd_q    <= pd_d;
      ln_q    <= ln_d;
      le_q    <= le_d;
      ls_q    <= ls_d;
      lw_q    <= lw_d;
    end
  end

  assign next_road  = next_q;
  assign cur_road   = cur_q;
  assign sec_left   = sec_q;
  assign phase_done = pd_q;
  assign light_n    = ln_q;
  assign light_e    = le_q;
  assign light_s    = ls_q;
  assign light_w    = lw_q;

endmodule

// File: tb/tb_signal_sequencer.sv
module tb_signal_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [1:0] next_road, cur_road;
  logic [1:0] light_n, light_e, light_s, light_w;
  logic [7:0] sec_left;
  logic       phase_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  signal_sequencer #(
    .TICKS_PER_SEC(2),
    .YELLOW_S     (2),
    .ALL_RED_S    (1),
    .MIN_GREEN    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .TGn       (TGn),
    .TGe       (TGe),
    .TGs       (TGs),
    .TGw       (TGw),
    .next_road (next_road),
    .cur_road  (cur_road),
    .light_n   (light_n),
    .light_e   (light_e),
    .light_s   (light_s),
    .light_w   (light_w),
    .sec_left  (sec_left),
    .phase_done(phase_done)
  );

  logic [1:0] lt [4];
  assign lt[0] = light_n;
  assign lt[1] = light_e;
  assign lt[2] = light_s;
  assign lt[3] = light_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic all_red();
    return (light_n == 2'b00) && (light_e == 2'b00) && (light_s == 2'b00) && (light_w == 2'b00);
  endfunction

  // Count consecutive sampled cycles matching a light condition, starting now.
  // mode 0..3 = road whose light must equal val, mode 4 = all lights red.
  task automatic meas(input int mode, input logic [1:0] val, output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (n < 200 && ((mode == 4) ? all_red() : (lt[mode] == val))) begin
      n++;
      if (phase_done) pulses++;
      @(negedge clk);
    end
  endtask

  int n, p, sl;

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    TGn   = 8'd10;
    TGe   = 8'd0;
    TGs   = 8'd4;
    TGw   = 8'd5;

    // Reset state
    cyc(3);
    chk("rst_all_red", all_red(), 1);
    chk("rst_next", next_road, 0);
    chk("rst_cur", cur_road, 3);
    chk("rst_sec", sec_left, 1);
    chk("rst_pd", phase_done, 0);

    // First green two cycles after release
    reset = 1'b1;
    cyc(1);
    chk("rel1_all_red", all_red(), 1);
    cyc(1);
    chk("n_green_on", light_n, 2'b10);
    chk("n_green_sec", sec_left, 10);
    chk("n_next", next_road, 1);
    chk("n_cur", cur_road, 0);

    // N green with late TG change: still 20 cycles
    cyc(5);
    TGn = 8'd40;
    meas(0, 2'b10, n, p);
    chk("n_green_len", n + 5, 20);
    chk("n_green_pd", p, 0);
    chk("n_yel_pd_now", phase_done, 1);
    chk("n_yel_sec", sec_left, 2);
    meas(0, 2'b01, n, p);
    chk("n_yel_len", n, 4);
    chk("n_yel_pd_cnt", p, 1);
    meas(4, 2'b00, n, p);
    chk("n_red_len", n, 2);

    // E green floored from TG=0
    chk("e_green_on", light_e, 2'b10);
    chk("e_sec_floor0", sec_left, 3);
    chk("e_cur", cur_road, 1);
    chk("e_next", next_road, 2);
    TGe = 8'd2;
    meas(1, 2'b10, n, p);
    chk("e_green_len", n, 6);
    meas(1, 2'b01, n, p);
    chk("e_yel_len", n, 4);
    meas(4, 2'b00, n, p);
    chk("e_red_len", n, 2);

    // S green with an enable pause of 5 cycles
    chk("s_green_on", light_s, 2'b10);
    chk("s_sec", sec_left, 4);
    cyc(3);
    chk("s_sec_pre_freeze", sec_left, 3);
    en = 1'b0;
    p = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (phase_done) p++;
    end
    chk("s_frozen_sec", sec_left, 3);
    chk("s_frozen_light", light_s, 2'b10);
    chk("s_frozen_pd", p, 0);
    en = 1'b1;
    meas(2, 2'b10, n, p);
    chk("s_green_len", n + 8, 13);
    meas(2, 2'b01, n, p);
    chk("s_yel_len", n, 4);
    meas(4, 2'b00, n, p);
    chk("s_red_len", n, 2);

    // W, then wrap back to N
    chk("w_sec", sec_left, 5);
    chk("w_next_wrap", next_road, 0);
    meas(3, 2'b10, n, p);
    chk("w_green_len", n, 10);
    meas(3, 2'b01, n, p);
    chk("w_yel_len", n, 4);
    meas(4, 2'b00, n, p);
    chk("w_red_len", n, 2);
    chk("wrap_cur", cur_road, 0);
    chk("wrap_next", next_road, 1);
    chk("n2_sec", sec_left, 40);
    meas(0, 2'b10, n, p);
    chk("n2_green_len", n, 80);
    meas(0, 2'b01, n, p);
    meas(4, 2'b00, n, p);

    // E again with TG=2 floored to 3
    chk("e2_sec_floor2", sec_left, 3);
    meas(1, 2'b10, n, p);
    chk("e2_green_len", n, 6);

    // Reset pulse during yellow
    chk("e2_in_yellow", light_e, 2'b01);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("mid_rst_all_red", all_red(), 1);
    chk("mid_rst_next", next_road, 0);
    chk("mid_rst_cur", cur_road, 3);
    chk("mid_rst_sec", sec_left, 1);
    chk("mid_rst_pd", phase_done, 0);
    cyc(2);
    chk("post_rst_green", light_n, 2'b10);
    chk("post_rst_sec", sec_left, 40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signal_sequencer.md
# signal_sequencer

Downstream consumer of the adaptation stage: drives the four approach lights (N, E, S, W) through a fixed round-robin of GREEN → YELLOW → ALL_RED phases. It presents `next_road` to the adaptation stage. At each green start it latches that road's adapted green time (`TGn/TGe/TGs/TGw`). Durations are in seconds, derived from the system clock by an internal prescaler.

## Interface
- `TICKS_PER_SEC`, 50_000_000: clock cycles per second; must be ≥1.
- `YELLOW_S`, 3: yellow duration in seconds; must be 1..255.
- `ALL_RED_S`, 2: all-red clearance in seconds; must be 1..255.
- `MIN_GREEN`, 5: floor on the green duration in seconds; must be 1..255.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 resets.
- `en`  in  1  1 = run; 0 = freeze prescaler, timer and state. Outputs hold.
- `TGn`, `TGe`, `TGs`, `TGw`  in  8 each  adapted green time per road, in seconds.
- `next_road`  out  2  road to be served next: 0=N, 1=E, 2=S, 3=W.
- `cur_road`  out  2  road currently or last served.
- `light_n`, `light_e`, `light_s`, `light_w`  out  2 each  00 = red, 01 = yellow, 10 = green. 11 is never driven.
- `sec_left`  out  8  seconds remaining in the current phase, N..1.
- `phase_done`  out  1  one-cycle pulse on the GREEN→YELLOW transition.

## Operation
- States: ALL_RED, GREEN, YELLOW.
- Reset values (while `reset`=0):
  - state = ALL_RED; `cur_road` = 3; `next_road` = 0.
  - All lights = 00; `sec_left` = ALL_RED_S; prescaler = 0; `phase_done` = 0.
- Seconds tick:
  - The prescaler counts 0..TICKS_PER_SEC-1.
  - `tick` = (prescaler == TICKS_PER_SEC-1) && `en`.
  - The prescaler clears on every phase entry, so a phase of N seconds lasts exactly N×TICKS_PER_SEC enabled cycles.
- Countdown: on `tick`, if `sec_left` > 1 then `sec_left` decrements; if `sec_left` == 1 the phase ends.
- ALL_RED end → GREEN:
  - `cur_road` ← `next_road`; `next_road` ← `next_road` + 1 (mod 4, so W wraps to N).
  - Green length G ← TG[`next_road`] (old value), raised to MIN_GREEN if smaller. TG=0 also maps to MIN_GREEN.
  - `sec_left` ← G.
- GREEN end → YELLOW: `sec_left` ← YELLOW_S; `phase_done` = 1 for that cycle only.
- YELLOW end → ALL_RED: `sec_left` ← ALL_RED_S.
- Lights:
  - Only `cur_road`'s light is non-red: 10 in GREEN, 01 in YELLOW.
  - All four lights are 00 in ALL_RED.
- TG inputs are sampled only on the ALL_RED→GREEN edge. Changes at any other time have no effect on the running phase.
- `en`=0: state, `sec_left`, prescaler and outputs all hold. `phase_done` is 0 while frozen.
- Reset mid-operation: `reset`=0 in any state returns to the reset values on that edge. Reset overrides `en`.

## Timing
- All outputs are registered.
- Phase transitions occur on the edge where `tick` && `sec_left`==1. The new light, `sec_left` and road values are visible in the following cycle.
- First green after reset release: after ALL_RED_S×TICKS_PER_SEC enabled cycles.
- `next_road` is stable for the whole GREEN+YELLOW+ALL_RED of `cur_road`. The adaptation stage gets that entire window to settle TG[`next_road`].
- Full cycle length = Σ(G_r + YELLOW_S + ALL_RED_S)×TICKS_PER_SEC cycles.
- `sec_left` is never 0 outside the reset transient.

## Test plan
All scenarios use TICKS_PER_SEC=2, YELLOW_S=2, ALL_RED_S=1, MIN_GREEN=3, `en`=1 unless stated.
- Reset: hold `reset`=0 for 3 cycles, TGn=10 → lights all 00, `next_road`=0, `sec_left`=1. 2 cycles after release, `light_n`=10, `sec_left`=10, `next_road`=1, `cur_road`=0.
- Phase lengths for road N, TGn=10:
  - `light_n`=10 for 20 cycles, then `phase_done` pulses once.
  - `light_n`=01 for 4 cycles, then all 00 for 2 cycles.
  - Then `light_e`=10 with `sec_left`=TGe.
- MIN_GREEN floor: TGe=0, then TGe=2 on the next round → each E green lasts 6 cycles (`sec_left` starts at 3).
- Late TG change: change TGn from 10 to 40 mid-green → current green is unchanged at 20 cycles. The next N green uses 40 (80 cycles).
- Enable pause: `en`=0 for 5 cycles mid-green → green stretches to 25 cycles; `sec_left` and prescaler frozen; no `phase_done` while frozen.
- Wrap and reset:
  - After the W all-red ends, `cur_road`=0 and `next_road`=1.
  - `reset`=0 for 1 cycle during a yellow → next cycle all lights 00, `next_road`=0, `sec_left`=1.
